// File: rtl/safety_lock_ctrl.sv
// Safety-lock controller: accepts a code word, compares it one digit per cycle, drives a timed
// unlock and enforces a lockout after repeated failures. Optional macro: SAFETY_LOCK_CODE_PROG_EN.
module safety_lock_ctrl #(
    parameter int DIGIT_W     = 4,
    parameter int CODE_LEN    = 4,
    parameter logic [DIGIT_W*CODE_LEN-1:0] DEFAULT_CODE = 16'h1234,
    parameter int MAX_FAIL    = 3,
    parameter int UNLOCK_CYC  = 8,
    parameter int LOCKOUT_CYC = 16
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             par_valid,
    input  logic [DIGIT_W*CODE_LEN-1:0]      par_data,
`ifdef SAFETY_LOCK_CODE_PROG_EN
    input  logic                             prog_valid,
    input  logic [DIGIT_W*CODE_LEN-1:0]      prog_code,
`endif
    output logic                             par_ready,
    output logic                             out,
    output logic                             output_valid,
    output logic                             fail,
    output logic                             locked_out,
    output logic [$clog2(MAX_FAIL+1)-1:0]    fail_cnt
);

    localparam int CW    = DIGIT_W * CODE_LEN;
    localparam int FC_W  = $clog2(MAX_FAIL + 1);
    localparam int CNT_W = $clog2(CODE_LEN) + 1;
    localparam int UT_W  = $clog2(UNLOCK_CYC) + 1;
    localparam int LT_W  = $clog2(LOCKOUT_CYC) + 1;

    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(CODE_LEN - 1);
    localparam logic [FC_W-1:0]  MAX_FAIL_C = FC_W'(MAX_FAIL);
    localparam logic [FC_W-1:0]  FC_ONE     = FC_W'(1);
    localparam logic [UT_W-1:0]  UNLOCK_LD  = UT_W'(UNLOCK_CYC);
    localparam logic [UT_W-1:0]  UT_ONE     = UT_W'(1);
    localparam logic [LT_W-1:0]  LOCKOUT_LD = LT_W'(LOCKOUT_CYC);
    localparam logic [LT_W-1:0]  LT_ONE     = LT_W'(1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SHIFT   = 3'd1;
    localparam logic [2:0] CHECK   = 3'd2;
    localparam logic [2:0] UNLOCK  = 3'd3;
    localparam logic [2:0] LOCKOUT = 3'd4;

    logic [2:0]       state_r, state_next_s;
    logic [CW-1:0]    shift_r, ref_r, code_s;
    logic [CNT_W-1:0] cnt_r;
    logic             mismatch_r, mismatch_next_s, last_shift_s, prog_hit_s;
    logic [FC_W-1:0]  fail_cnt_r, fail_inc_s;
    logic [UT_W-1:0]  unlock_tmr_r;
    logic [LT_W-1:0]  lock_tmr_r;
    logic             par_ready_r, out_r, output_valid_r, fail_r, locked_out_r;

`ifdef SAFETY_LOCK_CODE_PROG_EN
    logic [CW-1:0] code_r;

    // Stored code: reprogrammable only while unlocked.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            code_r <= DEFAULT_CODE;
        end else if (prog_hit_s) begin
            code_r <= prog_code;
        end else begin
            code_r <= code_r;
        end
    end

    assign code_s     = code_r;
    assign prog_hit_s = (state_r == UNLOCK) && prog_valid;
`else
    assign code_s     = DEFAULT_CODE;
    assign prog_hit_s = 1'b0;
`endif

    // The reference code is copied at transfer and shifted alongside the data, so both tops align.
    assign mismatch_next_s = mismatch_r | (shift_r[CW-1 -: DIGIT_W] != ref_r[CW-1 -: DIGIT_W]);
    assign last_shift_s    = (state_r == SHIFT) && (cnt_r == LAST_CNT);
    assign fail_inc_s      = fail_cnt_r + FC_ONE;

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (par_valid) state_next_s = SHIFT;
                else           state_next_s = IDLE;
            end
            SHIFT: begin
                if (cnt_r == LAST_CNT) state_next_s = CHECK;
                else                   state_next_s = SHIFT;
            end
            CHECK: begin
                if (!mismatch_r)                    state_next_s = UNLOCK;
                else if (fail_inc_s == MAX_FAIL_C)  state_next_s = LOCKOUT;
                else                                state_next_s = IDLE;
            end
            UNLOCK: begin
                if (prog_hit_s)                  state_next_s = UNLOCK;
                else if (unlock_tmr_r == UT_ONE) state_next_s = IDLE;
                else                             state_next_s = UNLOCK;
            end
            LOCKOUT: begin
                if (lock_tmr_r == LT_ONE) state_next_s = IDLE;
                else                      state_next_s = LOCKOUT;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State, serialiser and mismatch accumulation.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= IDLE;
            shift_r    <= '0;
            ref_r      <= '0;
            cnt_r      <= '0;
            mismatch_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (state_r == IDLE && par_valid) begin
                shift_r    <= par_data;
                ref_r      <= code_s;
                cnt_r      <= '0;
                mismatch_r <= 1'b0;
            end else if (state_r == SHIFT) begin
                shift_r    <= shift_r << DIGIT_W;
                ref_r      <= ref_r << DIGIT_W;
                cnt_r      <= cnt_r + CNT_W'(1);
                mismatch_r <= mismatch_next_s;
            end else begin
                shift_r    <= shift_r;
                ref_r      <= ref_r;
                cnt_r      <= cnt_r;
                mismatch_r <= mismatch_r;
            end
        end
    end

    // Failure counter and the two hold timers; none of them can wrap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fail_cnt_r   <= '0;
            unlock_tmr_r <= '0;
            lock_tmr_r   <= '0;
        end else begin
            if (state_r == CHECK)                                 fail_cnt_r <= mismatch_r ? fail_inc_s : '0;
            else if (state_r == LOCKOUT && lock_tmr_r == LT_ONE)  fail_cnt_r <= '0;
            else                                                  fail_cnt_r <= fail_cnt_r;

            if ((state_r == CHECK && !mismatch_r) || prog_hit_s) unlock_tmr_r <= UNLOCK_LD;
            else if (state_r == UNLOCK)                          unlock_tmr_r <= unlock_tmr_r - UT_ONE;
            else                                                 unlock_tmr_r <= unlock_tmr_r;

            if (state_r == CHECK)         lock_tmr_r <= LOCKOUT_LD;
            else if (state_r == LOCKOUT)  lock_tmr_r <= lock_tmr_r - LT_ONE;
            else                          lock_tmr_r <= lock_tmr_r;
        end
    end

    // Registered outputs; out also covers the CHECK cycle of a matching attempt.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            par_ready_r    <= 1'b1;
            out_r          <= 1'b0;
            output_valid_r <= 1'b0;
            fail_r         <= 1'b0;
            locked_out_r   <= 1'b0;
        end else begin
            par_ready_r    <= (state_next_s == IDLE);
            out_r          <= (state_next_s == UNLOCK) || (last_shift_s && !mismatch_next_s);
            output_valid_r <= last_shift_s;
            fail_r         <= last_shift_s && mismatch_next_s;
            locked_out_r   <= (state_next_s == LOCKOUT);
        end
    end

    assign par_ready    = par_ready_r;
    assign out          = out_r;
    assign output_valid = output_valid_r;
    assign fail         = fail_r;
    assign locked_out   = locked_out_r;
    assign fail_cnt     = fail_cnt_r;

endmodule

// File: tb/tb_safety_lock_ctrl.sv
// Directed bench for safety_lock_ctrl (default 4x4 instance plus a 3-bit x 6-digit instance).
module tb_safety_lock_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        par_valid = 1'b0;
    logic [15:0] par_data = 16'h0000;
    logic        par_ready, out, output_valid, fail, locked_out;
    logic [1:0]  fail_cnt;

    logic        par_valid3 = 1'b0;
    logic [17:0] par_data3 = 18'h0;
    logic        par_ready3, out3, output_valid3, fail3, locked_out3;
    logic [1:0]  fail_cnt3;

    int checks = 0;
    int failures = 0;

`ifdef SAFETY_LOCK_CODE_PROG_EN
    logic        prog_valid = 1'b0;
    logic [15:0] prog_code = 16'h0000;
    logic        prog_valid3 = 1'b0;
    logic [17:0] prog_code3 = 18'h0;
`endif

    safety_lock_ctrl u_dut (
        .clk(clk), .rstn(rstn), .par_valid(par_valid), .par_data(par_data),
`ifdef SAFETY_LOCK_CODE_PROG_EN
        .prog_valid(prog_valid), .prog_code(prog_code),
`endif
        .par_ready(par_ready), .out(out), .output_valid(output_valid), .fail(fail),
        .locked_out(locked_out), .fail_cnt(fail_cnt)
    );

    safety_lock_ctrl #(
        .DIGIT_W(3), .CODE_LEN(6), .DEFAULT_CODE(18'o123456)
    ) u_dut3 (
        .clk(clk), .rstn(rstn), .par_valid(par_valid3), .par_data(par_data3),
`ifdef SAFETY_LOCK_CODE_PROG_EN
        .prog_valid(prog_valid3), .prog_code(prog_code3),
`endif
        .par_ready(par_ready3), .out(out3), .output_valid(output_valid3), .fail(fail3),
        .locked_out(locked_out3), .fail_cnt(fail_cnt3)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Present a word in the current cycle T; returns in cycle T+1.
    task automatic send(input logic [15:0] d);
        par_valid = 1'b1;
        par_data  = d;
        tick();
        par_valid = 1'b0;
    endtask

    // Wrong attempt: returns in cycle T+6 after checking the result pulse and the new count.
    task automatic send_wrong(input logic [15:0] d, input logic [1:0] exp_cnt);
        send(d);
        ticks(4);
        check_eq("wrong_ov", output_valid, 1);
        check_eq("wrong_fail", fail, 1);
        check_eq("wrong_out", out, 0);
        tick();
        check_eq("wrong_cnt", fail_cnt, exp_cnt);
        check_eq("wrong_ov_pulse", output_valid, 0);
    endtask

    initial begin
        // Reset values
        ticks(2);
        check_eq("rst_ready", par_ready, 1);
        check_eq("rst_out", out, 0);
        check_eq("rst_ov", output_valid, 0);
        check_eq("rst_fail", fail, 0);
        check_eq("rst_lock", locked_out, 0);
        check_eq("rst_cnt", fail_cnt, 0);
        rstn = 1'b1;
        ticks(2);

        // Correct code: result at T+5, out through T+13 (CHECK plus 8 unlock cycles)
        send(16'h1234);
        check_eq("ok_ready_busy", par_ready, 0);
        ticks(3);
        check_eq("ok_ov_early", output_valid, 0);
        tick();
        check_eq("ok_ov", output_valid, 1);
        check_eq("ok_out", out, 1);
        check_eq("ok_fail", fail, 0);
        for (int i = 6; i <= 13; i++) begin
            tick();
            check_eq("ok_out_hold", out, 1);
            check_eq("ok_ready_low", par_ready, 0);
            check_eq("ok_ov_low", output_valid, 0);
        end
        tick();
        check_eq("ok_out_end", out, 0);
        check_eq("ok_ready_end", par_ready, 1);
        check_eq("ok_cnt", fail_cnt, 0);

        // Last digit wrong, then two more: lockout on the third
        send_wrong(16'h1235, 2'd1);
        check_eq("w1_ready", par_ready, 1);
        send_wrong(16'h0000, 2'd2);
        send_wrong(16'hFFFF, 2'd3);
        for (int i = 6; i <= 21; i++) begin
            check_eq("lock_hi", locked_out, 1);
            check_eq("lock_ready", par_ready, 0);
            check_eq("lock_out", out, 0);
            check_eq("lock_ov", output_valid, 0);
            par_valid = (i <= 20) ? 1'b1 : 1'b0;
            par_data  = 16'h1234;
            tick();
        end
        par_valid = 1'b0;
        check_eq("lock_end", locked_out, 0);
        check_eq("lock_cnt_clr", fail_cnt, 0);
        check_eq("lock_ready_end", par_ready, 1);
        ticks(6);
        check_eq("lock_no_accept_ov", output_valid, 0);
        check_eq("lock_no_accept_ready", par_ready, 1);

        // Two wrong (first and third digit), then correct: count clears
        send_wrong(16'h0234, 2'd1);
        send_wrong(16'h1204, 2'd2);
        send(16'h1234);
        ticks(4);
        check_eq("recov_ov", output_valid, 1);
        check_eq("recov_out", out, 1);
        check_eq("recov_fail", fail, 0);
        tick();
        check_eq("recov_cnt", fail_cnt, 0);
        ticks(8);
        check_eq("recov_ready", par_ready, 1);
        check_eq("recov_out_end", out, 0);

        // Reset during the second SHIFT cycle of a correct attempt
        send(16'h1234);
        tick();
        rstn = 1'b0;
        #1;
        check_eq("abort_ready", par_ready, 1);
        check_eq("abort_out", out, 0);
        check_eq("abort_ov", output_valid, 0);
        ticks(2);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("abort_no_ov", output_valid, 0);
            check_eq("abort_no_out", out, 0);
        end
        check_eq("abort_ready_after", par_ready, 1);

`ifdef SAFETY_LOCK_CODE_PROG_EN
        // Program a new code while unlocked; the unlock window restarts
        send(16'h1234);
        ticks(5);
        prog_valid = 1'b1;
        prog_code  = 16'hABCD;
        tick();
        prog_valid = 1'b0;
        ticks(7);
        check_eq("prog_out_ext", out, 1);
        tick();
        check_eq("prog_out_end", out, 0);
        check_eq("prog_ready", par_ready, 1);
        send_wrong(16'h1234, 2'd1);
        send(16'hABCD);
        ticks(4);
        check_eq("prog_new_ov", output_valid, 1);
        check_eq("prog_new_out", out, 1);
        check_eq("prog_new_fail", fail, 0);
        ticks(9);
        check_eq("prog_new_ready", par_ready, 1);
`endif

        // 3-bit x 6-digit instance: result at T+7
        par_valid3 = 1'b1;
        par_data3  = 18'o123456;
        tick();
        par_valid3 = 1'b0;
        check_eq("w3_ready_busy", par_ready3, 0);
        ticks(5);
        check_eq("w3_ov_early", output_valid3, 0);
        tick();
        check_eq("w3_ov", output_valid3, 1);
        check_eq("w3_out", out3, 1);
        check_eq("w3_fail", fail3, 0);
        ticks(8);
        check_eq("w3_out_hold", out3, 1);
        tick();
        check_eq("w3_out_end", out3, 0);
        check_eq("w3_ready_end", par_ready3, 1);
        par_valid3 = 1'b1;
        par_data3  = 18'o123457;
        tick();
        par_valid3 = 1'b0;
        ticks(6);
        check_eq("w3_bad_ov", output_valid3, 1);
        check_eq("w3_bad_fail", fail3, 1);
        tick();
        check_eq("w3_bad_cnt", fail_cnt3, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/safety_lock_ctrl.md
Name: safety_lock_ctrl

Overview:
Parametrised safety-lock controller. Accepts a complete multi-digit code word over a valid/ready handshake and serialises it internally, one digit per cycle. Compares the digits against a stored code and drives an unlock output. Also counts failed attempts and enforces a timed lockout. It replaces the fixed 4-bit converter-plus-detector pairing with one configurable block.

Parameters:
DIGIT_W, 4, bits per code digit (>=1)
CODE_LEN, 4, digits per code word (>=1)
DEFAULT_CODE, 16'h1234, reset code value, DIGIT_W*CODE_LEN bits; digit 0 = MS digit
MAX_FAIL, 3, consecutive failures that trigger lockout (>=1)
UNLOCK_CYC, 8, cycles out stays high after a match (>=1)
LOCKOUT_CYC, 16, cycles of lockout (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
par_valid  in  1  code word valid
par_data  in  DIGIT_W*CODE_LEN  code word; MS digit is compared first
par_ready  out  1  block can accept a code word
out  out  1  unlock level
output_valid  out  1  one-cycle pulse when an attempt result is decided
fail  out  1  one-cycle pulse, coincident with output_valid, on mismatch
locked_out  out  1  high during lockout
fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive-failure count

Behaviour:
- Reset (async assert, sync release): state=IDLE, all outputs 0 except par_ready=1; code register=DEFAULT_CODE; shift register, digit counter and mismatch flag cleared. Reset mid-operation aborts the attempt with no output_valid.
- Handshake: transfer occurs when par_valid && par_ready. par_ready=1 only in IDLE. Holding par_valid high outside IDLE has no effect. Data is captured at transfer.
- States:
  - IDLE: on transfer, load shift register, counter=0, mismatch=0 -> SHIFT.
  - SHIFT: each cycle compare top digit with code digit[counter] and OR the inequality into mismatch; shift left by DIGIT_W; counter++. After CODE_LEN compares -> CHECK. Every digit is always compared; there is no early exit on the first mismatch.
  - CHECK (1 cycle): output_valid=1.
    - Match: out=1, fail_cnt=0 -> UNLOCK.
    - Mismatch: fail=1, fail_cnt++. If the new count==MAX_FAIL -> LOCKOUT, else -> IDLE.
  - UNLOCK: out=1 for exactly UNLOCK_CYC cycles, the first being the cycle after CHECK. par_ready=0. Then out=0 -> IDLE.
  - LOCKOUT: locked_out=1 for exactly LOCKOUT_CYC cycles. par_ready=0. On exit fail_cnt=0 -> IDLE.
- Latency: transfer in cycle T -> output_valid in cycle T+CODE_LEN+1. The next accept is possible in cycle T+CODE_LEN+2 on a mismatch with no lockout.
- fail_cnt never exceeds MAX_FAIL and does not wrap.
- Timers are sized $clog2 of the parameter plus 1 and do not wrap.
- out and locked_out are never high together.
- output_valid and fail are registered; the other outputs are registered or decoded directly from state.

Optional Feature:
SAFETY_LOCK_CODE_PROG_EN
- Defined: adds ports prog_valid (in, 1) and prog_code (in, DIGIT_W*CODE_LEN).
  - When prog_valid is sampled high in UNLOCK, the code register loads prog_code.
  - The UNLOCK timer restarts from UNLOCK_CYC.
  - prog_valid in any other state is ignored.
  - The new code applies from the next attempt. Reset restores DEFAULT_CODE.
- Undefined: ports absent; code is the constant DEFAULT_CODE.

Test Plan:
- Reset, then par_data=16'h1234 with par_valid for 1 cycle -> output_valid and out rise at T+5; out high 8 cycles; par_ready low throughout; fail_cnt=0.
- par_data=16'h1235 -> output_valid=fail=1 at T+5, out=0, fail_cnt=1, par_ready=1 at T+6.
- Three wrong codes back-to-back -> fail_cnt 1,2,3; locked_out high 16 cycles; par_valid during lockout ignored; fail_cnt=0 and par_ready=1 afterwards.
- Two wrong codes then 16'h1234 -> unlock; fail_cnt cleared to 0.
- rstn asserted in the 2nd SHIFT cycle of a correct code -> no output_valid, outputs at reset values immediately, par_ready=1 after release.
- With SAFETY_LOCK_CODE_PROG_EN: unlock, pulse prog_valid with prog_code=16'hABCD -> 16'h1234 then fails, 16'hABCD unlocks. Also re-run the first scenario with DIGIT_W=3, CODE_LEN=6.
